// File: rtl/alu_op_sequencer.sv
// Command FIFO and single-issue sequencer for the IEEE-754 alu's level start/valid_out handshake.
// Optional sticky flag accumulator enabled by defining ALU_SEQ_STICKY_FLAGS_EN.
module alu_op_sequencer #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_op_a,
  input  logic [31:0]   in_op_b,
  input  logic [2:0]    in_op_code,
  input  logic          in_mode_fp,
  input  logic [1:0]    in_round_mode,
`ifdef ALU_SEQ_STICKY_FLAGS_EN
  input  logic          clr_sticky,
  output logic [4:0]    sticky_flags,
`endif
  output logic [31:0]   alu_op_a,
  output logic [31:0]   alu_op_b,
  output logic [2:0]    alu_op_code,
  output logic          alu_mode_fp,
  output logic [1:0]    alu_round_mode,
  output logic          alu_start,
  input  logic [31:0]   alu_result,
  input  logic          alu_valid_out,
  input  logic [4:0]    alu_flags,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_result,
  output logic [4:0]    out_flags,
  output logic [2:0]    out_op_code,
  output logic          busy,
  output logic [CW-1:0] fifo_count
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        mode;
    logic [1:0]  rm;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;

  state_t        state, state_nxt;
  cmd_t          mem [DEPTH];
  cmd_t          cmd_in, head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, capture;

  assign in_ready = (fifo_count != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign cmd_in   = '{a: in_op_a, b: in_op_b, op: in_op_code, mode: in_mode_fp, rm: in_round_mode};
  assign head     = mem[rd_ptr];
  assign busy     = (state != IDLE) || (fifo_count != '0) || out_valid;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Issue waits on the registered out_valid so a capture never overwrites an undrained result.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if ((fifo_count != '0) && !out_valid) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (alu_valid_out) begin
          capture   = 1'b1;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (!alu_valid_out) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_op_a       <= '0;
      alu_op_b       <= '0;
      alu_op_code    <= '0;
      alu_mode_fp    <= 1'b0;
      alu_round_mode <= '0;
      alu_start      <= 1'b0;
    end else if (pop) begin
      alu_op_a       <= head.a;
      alu_op_b       <= head.b;
      alu_op_code    <= head.op;
      alu_mode_fp    <= head.mode;
      alu_round_mode <= head.rm;
      alu_start      <= 1'b1;
    end else if (capture) begin
      alu_start      <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_flags   <= '0;
      out_op_code <= '0;
    end else if (capture) begin
      out_valid   <= 1'b1;
      out_result  <= alu_result;
      out_flags   <= alu_flags;
      out_op_code <= alu_op_code;
    end else if (out_valid && out_ready) begin
      out_valid   <= 1'b0;
    end
  end

`ifdef ALU_SEQ_STICKY_FLAGS_EN
  // A clear coinciding with a capture keeps only the newly captured flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             sticky_flags <= '0;
    else if (capture)    sticky_flags <= clr_sticky ? alu_flags : (sticky_flags | alu_flags);
    else if (clr_sticky) sticky_flags <= '0;
  end
`endif

endmodule
